alu_share_ctrl: RTL and testbench

Sequencer/arbiter that shares the project's single 4-bit ALU between two requesters. Round-robin arbitration over valid/ready request ports; the granted operation is registered and driven to the ALU. The result is sampled after a fixed settle time and returned on a valid/ready response port tagged with the requester id. Sits between the pin-level command decode and the ALU core inside the top-level user project.

---
 rtl/alu_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU between two requesters; result returned on a tagged valid/ready port.
// Optional per-requester grant counters are built when ALU_SHARE_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request, arbitration active
// EXEC  | operands driven to ALU, settle counter running
// RESP  | result held on rsp_* until accepted
module alu_share_ctrl #(
   parameter int DW      = 4,
   parameter int OPW     = 4,
   parameter int RW      = 8,
   parameter int ALU_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req_valid,
   output logic [1:0]     req_ready,
   input  logic [OPW-1:0] req_op0,
   input  logic [OPW-1:0] req_op1,
   input  logic [DW-1:0]  req_a0,
   input  logic [DW-1:0]  req_a1,
   input  logic [DW-1:0]  req_b0,
   input  logic [DW-1:0]  req_b1,
   output logic [OPW-1:0] alu_op,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic           alu_en,
   input  logic [RW-1:0]  alu_result,
   input  logic [3:0]     alu_flags,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [RW-1:0]  rsp_data,
   output logic [3:0]     rsp_flags,
`ifdef ALU_SHARE_STATS_EN
   output logic [7:0]     grant_cnt0,
   output logic [7:0]     grant_cnt1,
`endif
   output logic           busy
);

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic       last_grant;
   logic       grant;
   logic       accept;

   assign accept = |(req_valid & req_ready);

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      req_ready = 2'b00;
      alu_en    = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
            // rst gates ready so nothing is offered while the block is held in reset
            if (|req_valid && !rst) begin
               req_ready = grant ? 2'b10 : 2'b01;
            end
            if (accept) begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_en = 1'b1;
            if (cnt == 3'd0) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         last_grant <= 1'b1;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_flags  <= 4'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  alu_op     <= grant ? req_op1 : req_op0;
                  alu_a      <= grant ? req_a1  : req_a0;
                  alu_b      <= grant ? req_b1  : req_b0;
                  rsp_id     <= grant;
                  last_grant <= grant;
                  cnt        <= LAT_INIT;
               end
            end
            S_EXEC: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  rsp_data  <= alu_result;
                  rsp_flags <= alu_flags;
                  rsp_valid <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0 <= 8'd0;
         grant_cnt1 <= 8'd0;
      end else if (accept) begin
         if (!grant && grant_cnt0 != 8'hFF) begin
            grant_cnt0 <= grant_cnt0 + 8'd1;
         end
         if (grant && grant_cnt1 != 8'hFF) begin
            grant_cnt1 <= grant_cnt1 + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: a request-level model predicts grants, timing and responses.
// Grant counters are checked as well when ALU_SHARE_STATS_EN is defined.
module tb_alu_share_ctrl;

   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req_valid, req_ready;
   logic [3:0] req_op0, req_op1, req_a0, req_a1, req_b0, req_b1;
   logic [3:0] alu_op, alu_a, alu_b;
   logic       alu_en;
   logic [7:0] alu_result;
   logic [3:0] alu_flags;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flags;
   logic       busy;
`ifdef ALU_SHARE_STATS_EN
   logic [7:0] grant_cnt0, grant_cnt1;
`endif

   always #5 clk = ~clk;

   alu_share_ctrl #(.DW(4), .OPW(4), .RW(8), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags),
`ifdef ALU_SHARE_STATS_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
      .busy(busy)
   );

   // Behavioural ALU: 0 ADD, 1 SUB, 2 MUL, 3 AND, else XOR. Returns {carry,zero,neg,ovf,result}.
   function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] r;
      logic       c, v;
      case (op)
         4'd0: begin r = 8'(a) + 8'(b); c = r[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
         4'd1: begin r = 8'(a) - 8'(b); c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
         4'd2: begin r = 8'(a) * 8'(b); c = (r[7:4] != 4'd0); v = c; end
         4'd3: begin r = {4'd0, a & b}; c = 1'b0; v = 1'b0; end
         default: begin r = {4'd0, a ^ b}; c = 1'b0; v = 1'b0; end
      endcase
      return {c, (r == 8'd0), r[7], v, r};
   endfunction

   assign {alu_flags, alu_result} = alu_f(alu_op, alu_a, alu_b);

   typedef struct {
      logic       id;
      logic [7:0] d;
      logic [3:0] f;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Request-level model: who should be offered ready, when the response appears, what it carries.
   bit   m_busy = 1'b0;
   int   m_cnt  = 0;
   logic m_last = 1'b1;
   int   m_gc[2] = '{0, 0};

   always @(negedge clk) begin
      logic       g;
      logic [1:0] exp_rdy;
      logic [11:0] res;
      if (rst) begin
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         m_busy = 1'b0;
         m_last = 1'b1;
         m_gc   = '{0, 0};
         exp_q.delete();
      end else if (m_busy) begin
         m_cnt++;
         chk("busy_in_op", 32'(busy), 32'd1);
         chk("ready_in_op", 32'(req_ready), 32'd0);
         chk("alu_en", 32'(alu_en), 32'(m_cnt <= LAT + 1));
         chk("rsp_valid_timing", 32'(rsp_valid), 32'(m_cnt >= LAT + 2));
         if (m_cnt >= LAT + 2 && rsp_ready) m_busy = 1'b0;
      end else begin
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("idle_alu_en", 32'(alu_en), 32'd0);
         g       = (req_valid == 2'b11) ? !m_last : req_valid[1];
         exp_rdy = (req_valid == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (req_valid != 2'b00) begin
            res = g ? alu_f(req_op1, req_a1, req_b1) : alu_f(req_op0, req_a0, req_b0);
            exp_q.push_back('{id: g, d: res[7:0], f: res[11:8]});
            m_last = g;
            m_busy = 1'b1;
            m_cnt  = 0;
            if (m_gc[g] < 255) m_gc[g]++;
         end
      end
   end

   // Monitor: whatever is presented must match the head of the queue; pops on handshake.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected_qsize", 32'(exp_q.size()), 32'd1);
         end else begin
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].d));
            chk("rsp_flags", 32'(rsp_flags), 32'(exp_q[0].f));
            if (rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   logic [1:0] last_hs;
   int         acc;
   logic       gr_log[$];

   task automatic tick();
      @(negedge clk);
      last_hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~last_hs;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      if (i == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1; end
      else        begin req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1; end
   endtask

   task automatic rnd_req(input int i);
      set_req(i, 4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
   endtask

   task automatic wait_accept(input string nm);
      int k;
      k = 0;
      last_hs = 2'b00;
      while (last_hs == 2'b00 && k < 20) begin tick(); k++; end
      if (last_hs == 2'b00) chk({nm, "_accept_timeout"}, 32'(k), 32'd0);
   endtask

   task automatic drain();
      int k;
      rsp_ready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || busy) && k < 40) begin tick(); k++; end
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b0;
      req_valid = 2'b00;
      {req_op0, req_op1, req_a0, req_a1, req_b0, req_b1} = '0;
      rnd_req(0);
      rnd_req(1);
      @(posedge clk);
      #1;
      chk("reset_alu_op", 32'(alu_op), 32'd0);
      chk("reset_alu_ab", 32'({alu_a, alu_b}), 32'd0);
      chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_flags}), 32'd0);
      chk("reset_ready_with_valid", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // contention from reset: both valid continuously
      rsp_ready = 1'b1;
      acc = 0;
      for (int k = 0; k < 60 && acc < 4; k++) begin
         tick();
         if (last_hs[0]) begin gr_log.push_back(1'b0); acc++; end
         if (last_hs[1]) begin gr_log.push_back(1'b1); acc++; end
         for (int i = 0; i < 2; i++) if (!req_valid[i]) rnd_req(i);
      end
      req_valid = 2'b00;
      chk("contention_ops", 32'(acc), 32'd4);
      for (int i = 0; i < 4 && i < gr_log.size(); i++)
         chk("contention_order", 32'(gr_log[i]), 32'(i % 2));
      drain();

      // single ADD 5+3 with ready held high
      set_req(0, 4'd0, 4'd5, 4'd3);
      wait_accept("single");
      drain();

      // backpressure on MUL F*F with requester 1 waiting
      rsp_ready = 1'b0;
      set_req(0, 4'd2, 4'hF, 4'hF);
      wait_accept("mul");
      rnd_req(1);
      repeat (LAT + 1 + 5) tick();
      rsp_ready = 1'b1;
      wait_accept("after_bp");
      chk("after_bp_grant", 32'(last_hs), 32'd2);
      drain();

      // reset one cycle into EXEC, then tie must go to requester 0
      rnd_req(0);
      wait_accept("pre_reset");
      rst = 1'b1;
      #1;
      chk("midop_rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
      chk("midop_rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_flags}), 32'd0);
      chk("midop_rst_busy_en", 32'({busy, alu_en}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rnd_req(0);
      rnd_req(1);
      wait_accept("tie");
      chk("tie_after_reset", 32'(last_hs), 32'd1);
      req_valid = 2'b00;
      drain();

      // randomized traffic with random backpressure and occasional withdrawn requests
      for (int k = 0; k < 300; k++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) rnd_req(i);
            else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
         end
         tick();
      end
      req_valid = 2'b00;
      drain();

      // 300 ops from requester 1 to saturate its counter
      rsp_ready = 1'b1;
      acc = 0;
      for (int k = 0; k < 3000 && acc < 300; k++) begin
         if (!req_valid[1]) rnd_req(1);
         tick();
         if (last_hs[1]) acc++;
      end
      req_valid = 2'b00;
      chk("r1_ops", 32'(acc), 32'd300);
      drain();
`ifdef ALU_SHARE_STATS_EN
      chk("grant_cnt0", 32'(grant_cnt0), 32'(m_gc[0]));
      chk("grant_cnt1", 32'(grant_cnt1), 32'(m_gc[1]));
      chk("grant_cnt1_sat", 32'(grant_cnt1), 32'd255);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
